// File: rtl/scs8hd_xor3_sched_pkg.sv
// Shared types and elaboration helpers for the XOR3 parity scheduler.
package scs8hd_xor3_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFold,
      StHold
   } sched_state_e;

   // Smallest legal data word: one XOR3 fold consumes two bits.
   localparam int unsigned DwMin = 2;

   // Word widths must be even so every fold step consumes a full bit pair.
   function automatic bit dw_valid(input int unsigned dw);
      return (dw >= DwMin) && ((dw % 2) == 0);
   endfunction

   // Ceiling log2, never below 1 so single-entry indices still have a bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/scs8hd_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, cyclically.
module scs8hd_rr_arb
   import scs8hd_xor3_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   assign any_o = |req_i;

   if (NREQ == 1) begin : g_single
      // Nothing to arbitrate; the pointer is irrelevant.
      logic unused_ptr;
      assign unused_ptr = ^ptr_i;
      assign gnt_o      = req_i;
      assign idx_o      = '0;
   end else begin : g_multi
      logic           found;
      logic [IDW-1:0] kk;

      // Scan from the pointer and keep the first hit.
      always_comb begin
         gnt_o = '0;
         idx_o = '0;
         found = 1'b0;
         kk    = '0;
         for (int unsigned i = 0; i < NREQ; i++) begin
            kk = IDW'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[kk]) begin
               found     = 1'b1;
               gnt_o[kk] = 1'b1;
               idx_o     = kk;
            end
         end
      end
   end

endmodule

// File: rtl/scs8hd_xor3_parity_sched.sv
// Time-shared parity engine: grants one requester at a time and folds its word
// through a single XOR3 slice, two bits per cycle, returning parity via valid/ready.
module scs8hd_xor3_parity_sched
   import scs8hd_xor3_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 16,
   parameter int unsigned IDW  = clog2(NREQ)
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*DW-1:0] DATA,
   output logic [NREQ-1:0]    GNT,
   output logic               BUSY,
   output logic               RES_VALID,
   input  logic               RES_READY,
   output logic [IDW-1:0]     RES_ID,
   output logic               RES_PARITY
);

   localparam bit          DwOk    = dw_valid(DW);
   localparam int unsigned CW      = clog2(DW / 2);
   localparam logic [CW-1:0] CntLast = CW'(DW / 2 - 1);

   if (!DwOk) begin : g_dw_chk
      $error("DW must be even and at least 2");
   end

   sched_state_e   state_q;
   logic [IDW-1:0] rr_ptr_q;
   logic [IDW-1:0] gid_q;
   logic [DW-1:0]  shreg_q;
   logic [CW-1:0]  cnt_q;
   logic           acc_q;
   logic           res_valid_q;
   logic [IDW-1:0] res_id_q;
   logic           res_parity_q;

   logic [NREQ-1:0] arb_gnt;
   logic [IDW-1:0]  arb_idx;
   logic            arb_any;
   logic [DW-1:0]   sel_word;
   logic            fold_acc;
   logic [IDW-1:0]  ptr_next;

   scs8hd_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req_i (REQ),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   // Pick the granted requester's word for capture.
   always_comb begin
      sel_word = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (arb_gnt[k]) sel_word = DATA[k*DW +: DW];
      end
   end

   // The shared XOR3 slice.
   assign fold_acc = acc_q ^ shreg_q[0] ^ shreg_q[1];

   // Fairness resumes just after the requester whose result was accepted.
   assign ptr_next = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;

   assign GNT        = (state_q == StIdle) ? arb_gnt : '0;
   assign BUSY       = (state_q != StIdle);
   assign RES_VALID  = res_valid_q;
   assign RES_ID     = res_id_q;
   assign RES_PARITY = res_parity_q;

   // Scheduler FSM with registered result outputs; reset aborts any operation.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         gid_q        <= '0;
         shreg_q      <= '0;
         cnt_q        <= '0;
         acc_q        <= 1'b0;
         res_valid_q  <= 1'b0;
         res_id_q     <= '0;
         res_parity_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (arb_any) begin
                  shreg_q <= sel_word;
                  acc_q   <= 1'b0;
                  cnt_q   <= '0;
                  gid_q   <= arb_idx;
                  state_q <= StFold;
               end
            end
            StFold: begin
               acc_q   <= fold_acc;
               shreg_q <= shreg_q >> 2;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  res_parity_q <= fold_acc;
                  res_id_q     <= gid_q;
                  res_valid_q  <= 1'b1;
                  state_q      <= StHold;
               end
            end
            StHold: begin
               if (RES_READY) begin
                  res_valid_q <= 1'b0;
                  rr_ptr_q    <= ptr_next;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_scs8hd_xor3_parity_sched.sv
// Directed self-checking bench for the XOR3 parity scheduler (NREQ=4, DW=16).
module tb_scs8hd_xor3_parity_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 16;
   localparam int unsigned IDW  = 2;

   logic               CLK = 1'b0;
   logic               RESET;
   logic [NREQ-1:0]    REQ;
   logic [NREQ*DW-1:0] DATA;
   logic [NREQ-1:0]    GNT;
   logic               BUSY;
   logic               RES_VALID;
   logic               RES_READY;
   logic [IDW-1:0]     RES_ID;
   logic               RES_PARITY;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_gnt_cyc = 0;

   scs8hd_xor3_parity_sched #(
      .NREQ (NREQ),
      .DW   (DW),
      .IDW  (IDW)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .REQ        (REQ),
      .DATA       (DATA),
      .GNT        (GNT),
      .BUSY       (BUSY),
      .RES_VALID  (RES_VALID),
      .RES_READY  (RES_READY),
      .RES_ID     (RES_ID),
      .RES_PARITY (RES_PARITY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1-2 time units after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_word(input int k, input logic [DW-1:0] w);
      DATA[k*DW +: DW] = w;
   endtask

   task automatic do_reset();
      RESET     = 1'b1;
      REQ       = '0;
      RES_READY = 1'b0;
      tick();
      RESET = 1'b0;
      settle();
   endtask

   // Single request on requester k: checks grant pulse, latency and result, then accepts.
   task automatic run_single(input int k, input logic [DW-1:0] w, input logic exp_par);
      set_word(k, w);
      REQ = NREQ'(1 << k);
      settle();
      check("single_gnt", 32'(GNT), 32'(1 << k));
      tick();
      REQ = '0;
      settle();
      check("single_gnt_pulse", 32'(GNT), 0);
      check("single_busy", 32'(BUSY), 1);
      repeat (7) tick();
      check("single_valid_early", 32'(RES_VALID), 0);
      tick();
      check("single_valid", 32'(RES_VALID), 1);
      check("single_id", 32'(RES_ID), 32'(k));
      check("single_parity", 32'(RES_PARITY), 32'(exp_par));
      RES_READY = 1'b1;
      tick();
      RES_READY = 1'b0;
      settle();
      check("single_accept_valid", 32'(RES_VALID), 0);
      check("single_accept_busy", 32'(BUSY), 0);
   endtask

   // Wait (bounded) for the next grant; check who and, if gap>0, the cycle spacing.
   task automatic expect_grant(input string tag, input int idx, input int gap);
      int w;
      w = 0;
      while (GNT == '0 && w < 40) begin
         tick();
         w++;
      end
      check({tag, "_gnt"}, 32'(GNT), 32'(1 << idx));
      if (gap > 0) check({tag, "_gap"}, 32'(cyc - last_gnt_cyc), 32'(gap));
      last_gnt_cyc = cyc;
      tick();
   endtask

   task automatic drain();
      int w;
      REQ = '0;
      RES_READY = 1'b1;
      w = 0;
      while (BUSY && w < 40) begin
         tick();
         w++;
      end
      check("drain_idle", 32'(BUSY), 0);
      RES_READY = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      RESET     = 1'b1;
      REQ       = '0;
      DATA      = '0;
      RES_READY = 1'b0;
      repeat (2) tick();
      RESET = 1'b0;
      settle();
      check("rst_gnt", 32'(GNT), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_valid", 32'(RES_VALID), 0);
      check("rst_id", 32'(RES_ID), 0);
      check("rst_parity", 32'(RES_PARITY), 0);

      // Parity values on requester 0.
      run_single(0, 16'h0001, 1'b1);
      run_single(0, 16'hFFFF, 1'b0);
      run_single(0, 16'h8001, 1'b0);
      run_single(0, 16'h7000, 1'b1);

      // Round robin with all requesters active; back-to-back spacing is DW/2+2.
      do_reset();
      set_word(0, 16'h0001);
      set_word(1, 16'h0003);
      set_word(2, 16'h0007);
      set_word(3, 16'h000F);
      REQ       = 4'b1111;
      RES_READY = 1'b1;
      settle();
      expect_grant("rr0", 0, 0);
      expect_grant("rr1", 1, 10);
      expect_grant("rr2", 2, 10);
      expect_grant("rr3", 3, 10);
      expect_grant("rr4", 0, 10);
      drain();

      // Backpressure: result holds, no grants while waiting.
      do_reset();
      set_word(1, 16'h0007);
      REQ = 4'b0010;
      settle();
      check("bp_gnt", 32'(GNT), 32'h2);
      tick();
      REQ = 4'b0001;
      repeat (8) tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(RES_VALID), 1);
         check("bp_id", 32'(RES_ID), 1);
         check("bp_parity", 32'(RES_PARITY), 1);
         check("bp_gnt_hold", 32'(GNT), 0);
         check("bp_busy", 32'(BUSY), 1);
         tick();
      end
      RES_READY = 1'b1;
      settle();
      check("bp_valid_before_accept", 32'(RES_VALID), 1);
      tick();
      RES_READY = 1'b0;
      settle();
      check("bp_accept_valid", 32'(RES_VALID), 0);
      check("bp_accept_busy", 32'(BUSY), 0);
      check("bp_next_gnt", 32'(GNT), 32'h1);

      // Capture isolation: data change after grant has no effect.
      do_reset();
      set_word(2, 16'h0003);
      REQ = 4'b0100;
      settle();
      check("cap_gnt", 32'(GNT), 32'h4);
      tick();
      set_word(2, 16'h0001);
      REQ = '0;
      repeat (8) tick();
      check("cap_valid", 32'(RES_VALID), 1);
      check("cap_id", 32'(RES_ID), 2);
      check("cap_parity", 32'(RES_PARITY), 0);
      RES_READY = 1'b1;
      tick();
      RES_READY = 1'b0;

      // Reset mid-fold (rr_ptr was 3): aborts, then pointer restarts at 0.
      set_word(0, 16'hFFFF);
      REQ = 4'b0001;
      settle();
      check("mid_gnt", 32'(GNT), 32'h1);
      tick();
      REQ = '0;
      repeat (4) tick();
      RESET = 1'b1;
      REQ   = 4'b1100;
      settle();
      check("mid_gnt_fold", 32'(GNT), 0);
      tick();
      RESET = 1'b0;
      settle();
      check("mid_busy", 32'(BUSY), 0);
      check("mid_valid", 32'(RES_VALID), 0);
      check("mid_id", 32'(RES_ID), 0);
      check("mid_parity", 32'(RES_PARITY), 0);
      check("mid_regrant", 32'(GNT), 32'h4);
      tick();
      REQ = '0;
      repeat (8) tick();
      check("mid_res_valid", 32'(RES_VALID), 1);
      check("mid_res_id", 32'(RES_ID), 2);
      check("mid_res_parity", 32'(RES_PARITY), 1);
      drain();

      // Skip idle requesters: rr_ptr=2 with REQ=1010 -> 3, 1, 3.
      do_reset();
      run_single(1, 16'h0003, 1'b0);
      REQ       = 4'b1010;
      RES_READY = 1'b1;
      settle();
      expect_grant("skip0", 3, 0);
      expect_grant("skip1", 1, 10);
      expect_grant("skip2", 3, 10);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
